// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready load/store port over a word-organised RAM window.
// Define DMEM_MISALIGN_ERR_EN to fault misaligned half/word accesses instead of force-aligning them.
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int          LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam int          CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic             rw_q, rw_d;
    logic [31:0]      addr_q, addr_d;
    logic [1:0]       size_q, size_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          do_access;
    logic [31:0]   off;
    logic          in_range;
    logic          misalign;
    logic          fault;
    logic [AW-1:0] word_idx;
    logic [31:0]   word_rd;
    logic [31:0]   rd_data;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;
    logic          mem_we;

    assign req_ready  = !reset && (state_q == S_IDLE || (state_q == S_RESP && resp_ready));
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // Window check is a single unsigned compare, so addresses below BASE_ADDR wrap high and fault.
    assign off       = addr_q - BASE_ADDR;
    assign in_range  = (off < SPAN_BYTES);
    assign word_idx  = off[AW+1:2];
    assign word_rd   = mem[word_idx];
    assign do_access = (state_q == S_WAIT) && (lat_cnt_q == '0);

`ifdef DMEM_MISALIGN_ERR_EN
    assign misalign = ((size_q == 2'd1) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign fault  = !in_range || misalign;
    assign mem_we = do_access && rw_q && !fault && !reset;

    always_comb begin
        rd_data  = word_rd;
        byte_en  = 4'b1111;
        wr_lanes = wdata_q;
        case (size_q)
            2'd0: begin
                rd_data  = (word_rd >> {addr_q[1:0], 3'b000}) & 32'h0000_00FF;
                byte_en  = 4'b0001 << addr_q[1:0];
                wr_lanes = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                rd_data  = (word_rd >> {addr_q[1], 4'b0000}) & 32'h0000_FFFF;
                byte_en  = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            S_WAIT: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - CNT_W'(1);
                end else begin
                    resp_err_d   = fault;
                    resp_rdata_d = (fault || rw_q) ? 32'h0 : rd_data;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: ;
        endcase

        // A new accept overrides the IDLE/RESP exit above, giving back-to-back handshakes.
        if (accept) begin
            rw_d      = req_rw;
            addr_d    = req_addr;
            size_d    = req_size;
            wdata_d   = req_wdata;
            lat_cnt_d = CNT_W'(LATENCY - 1);
            state_d   = S_WAIT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lat_cnt_q    <= '0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Request fields need no reset: they are only consumed after an accept reloads them.
    always_ff @(posedge clock) begin
        rw_q    <= rw_d;
        addr_q  <= addr_d;
        size_q  <= size_d;
        wdata_q <= wdata_d;
    end

    // NOTE: the RAM is deliberately left out of reset so it maps onto plain block memory.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder with hand sequences for backpressure and reset.
module tb_dmem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          LAT   = 2;
    localparam int          TMO   = 20;

`ifdef DMEM_MISALIGN_ERR_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_rw;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called right after the accepting edge; returns the number of edges until resp_valid.
    task automatic wait_resp(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clock);
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            lat++;
        end
    endtask

    task automatic do_req(input logic rw, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat, output bit ok);
        int w;
        @(negedge clock);
        req_valid  = 1'b1;
        req_rw     = rw;
        req_addr   = addr;
        req_size   = size;
        req_wdata  = wdata;
        resp_ready = 1'b1;
        w = 0;
        while (!req_ready && w < TMO) begin
            @(negedge clock);
            w++;
        end
        ok = 1'b0;
        rdata = 32'h0;
        err = 1'b0;
        lat = 0;
        if (w == TMO) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
        wait_resp(lat, ok);
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge clock);
        #1;
    endtask

    task automatic run_req(input string tag, input logic rw, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          ok;
        do_req(rw, addr, size, wdata, rd, er, lat, ok);
        check({tag, "_timeout"}, 32'(ok), 32'd1);
        check({tag, "_rdata"}, rd, exp_rdata);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
    endtask

    initial begin
        logic [31:0] held;
        int          lat;
        bit          ok;

        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0;
        req_size = 2'd0; req_wdata = '0; resp_ready = 1'b1;

        // rw, addr, size, wdata, expected rdata, expected err
        vecs.push_back('{1'b1, 32'h0100_0010, 2'd2, 32'hDEAD_BEEF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0100_0010, 2'd2, 32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0100_0010, 2'd2, 32'h1122_3344, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 32'h0100_0011, 2'd0, 32'h0000_00AA, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0100_0010, 2'd2, 32'h0,         32'h1122_AA44, 1'b0});
        vecs.push_back('{1'b0, 32'h0100_0013, 2'd0, 32'h0,         32'h0000_0011, 1'b0});
        vecs.push_back('{1'b0, 32'h0100_0012, 2'd1, 32'h0,         32'h0000_1122, 1'b0});
        vecs.push_back('{1'b0, 32'h00FF_FFFC, 2'd2, 32'h0,         32'h0, 1'b1});
        vecs.push_back('{1'b0, BASE + 32'(4*DEPTH), 2'd2, 32'h0,   32'h0, 1'b1});
        vecs.push_back('{1'b1, 32'h0100_0000, 2'd2, 32'h1234_5678, 32'h0, 1'b0});
        vecs.push_back('{1'b1, BASE + 32'(4*DEPTH), 2'd0, 32'h55,  32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h0100_0000, 2'd2, 32'h0,         32'h1234_5678, 1'b0});
        vecs.push_back('{1'b0, 32'h0100_0000, 2'd3, 32'h0,         32'h1234_5678, 1'b0});
        vecs.push_back('{1'b1, 32'h0100_0FFC, 2'd2, 32'hA5C3_5AF0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0100_0FFC, 2'd2, 32'h0,         32'hA5C3_5AF0, 1'b0});
        vecs.push_back('{1'b0, 32'h0100_0FFF, 2'd0, 32'h0,         32'h0000_00A5, 1'b0});
        vecs.push_back('{1'b1, 32'h0100_0030, 2'd2, 32'h0,         32'h0, 1'b0});
        vecs.push_back('{1'b1, 32'h0100_0031, 2'd1, 32'h0000_BEEF, 32'h0, MIS});
        vecs.push_back('{1'b1, 32'h0100_0032, 2'd1, 32'h0000_CAFE, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0100_0030, 2'd2, 32'h0,
                         MIS ? 32'hCAFE_0000 : 32'hCAFE_BEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h0100_0012, 2'd2, 32'h0,
                         MIS ? 32'h0 : 32'h1122_AA44, MIS});

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        foreach (vecs[i]) begin
            run_req($sformatf("v%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].size,
                    vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Backpressure: hold the response, offer a write that must be ignored, then overlap.
        @(negedge clock);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h0100_0010; req_size = 2'd2;
        resp_ready = 1'b0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        wait_resp(lat, ok);
        check("bp_timeout", 32'(ok), 32'd1);
        check("bp_lat", 32'(lat), 32'(LAT));
        held = resp_rdata;
        check("bp_rdata", held, 32'h1122_AA44);
        req_valid = 1'b1; req_rw = 1'b1; req_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("bp_hold%0d_valid", i), 32'(resp_valid), 32'd1);
            check($sformatf("bp_hold%0d_rdata", i), resp_rdata, held);
            check($sformatf("bp_hold%0d_ready", i), 32'(req_ready), 32'd0);
        end
        req_rw = 1'b0; req_addr = 32'h0100_0000; resp_ready = 1'b1;
        #1 check("bp_overlap_ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        wait_resp(lat, ok);
        check("bp2_timeout", 32'(ok), 32'd1);
        check("bp2_lat", 32'(lat), 32'(LAT));
        check("bp2_rdata", resp_rdata, 32'h1234_5678);
        @(posedge clock);
        #1;
        run_req("bp_noclobber", 1'b0, 32'h0100_0010, 2'd2, 32'h0, 32'h1122_AA44, 1'b0);

        // Reset while a write sits in WAIT: it must never commit.
        run_req("rw_init", 1'b1, 32'h0100_0020, 2'd2, 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 32'h0100_0020; req_size = 2'd2;
        req_wdata = 32'h0000_0055;
        @(posedge clock);
        #1 req_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rw_rst_valid", 32'(resp_valid), 32'd0);
        check("rw_rst_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("rw_post_ready", 32'(req_ready), 32'd1);
        check("rw_post_valid", 32'(resp_valid), 32'd0);
        run_req("rw_read", 1'b0, 32'h0100_0020, 2'd2, 32'h0, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving load/store requests from the pipeline's memory stage over a valid/ready request channel and a valid/ready response channel. It stores a window of word-organised RAM at a fixed base address and performs byte, half and word accesses with lane selection. Responses are delivered a configurable number of cycles after acceptance, so the core can be tested against non-zero memory latency.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words of storage (power of two, ≥ 4)
- BASE_ADDR, 32'h01000000, byte address of word 0
- LATENCY, 2, clock edges from request acceptance to resp_valid (≥ 1)

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_rw  in  1  1 = write (store), 0 = read (load)
- req_addr  in  32  byte address
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  load data, right-justified, zero-extended; 0 for writes and errors
- resp_err  out  1  access faulted (out of range; misaligned when enabled)

## Operation
- FSM states: IDLE, WAIT, RESP; lat_cnt is a counter wide enough for LATENCY-1.
- req_ready = !reset & (state==IDLE | (state==RESP & resp_ready)); requests are accepted only when req_valid & req_ready.
- Accept: latch rw/addr/size/wdata, lat_cnt <= LATENCY-1, state <= WAIT.
- WAIT: if lat_cnt != 0, decrement; else perform access, load resp_rdata/resp_err, state <= RESP.
- RESP: resp_valid = 1. On resp_ready, go to IDLE, or go to WAIT if a new request is accepted in the same cycle.
- Address: off = req_addr - BASE_ADDR (32-bit unsigned); in range iff off < 4*DEPTH_WORDS; word index = off[..:2].
- Out of range: no write, rdata 0, err 1. No aliasing into the array.
- Write lanes: byte → lane addr[1:0] from wdata[7:0]; half → lanes {addr[1],0},{addr[1],1} from wdata[15:0]; word → all four lanes.
- Read: byte → {24'b0, lane addr[1:0]}; half → {16'b0, half addr[1]}; word → full word. Sign extension is the core's job.
- Little-endian: lane 0 = bits [7:0].
- The memory array is not cleared by reset.

## Timing
- Reset values: state IDLE, lat_cnt 0, resp_valid 0, resp_rdata 0, resp_err 0, req_ready 0 during reset and 1 in the cycle after.
- Accept at edge N: resp_valid is first high after edge N+LATENCY. Minimum period between accepts is LATENCY+1 cycles.
- The memory write commits on the edge leaving WAIT. Any read accepted after that edge sees the new data.
- While resp_valid & !resp_ready, resp_rdata and resp_err stay stable and req_ready = 0.
- Simultaneous response handshake and new request: both complete on the same edge, and resp_valid drops for LATENCY cycles.
- Reset mid-operation discards the pending request. A write still in WAIT is never committed.
- Request inputs are ignored whenever req_ready = 0.

## Configuration
- DMEM_MISALIGN_ERR_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, gives resp_err=1, rdata 0 and no write.
- Not defined: low address bits below the access size are ignored (access is force-aligned), and resp_err reports out-of-range only.

## Test plan
- LATENCY=2, reset, then word write 0xDEADBEEF @0x01000010 → resp_valid 2 edges after accept, err 0, rdata 0; word read @0x01000010 → 0xDEADBEEF.
- Word 0x11223344 @0x01000010, then byte write 0xAA @0x01000011 → word read 0x1122AA44; byte read @0x01000013 → 0x00000011; half read @0x01000012 → 0x00001122.
- Read response held with resp_ready=0 for 5 cycles → resp_valid and rdata stable, req_ready 0; raise resp_ready with req_valid → new request accepted on that edge, next response LATENCY edges later.
- Read @0x00FFFFFC and @BASE_ADDR+4*DEPTH_WORDS → err 1, rdata 0; write 0x55 @BASE_ADDR+4*DEPTH_WORDS → word 0 unchanged.
- Reset asserted while a write of 0x55 @0x01000020 is in WAIT → word unchanged, resp_valid 0, req_ready 1 the cycle after reset deasserts.
- Half write 0xBEEF @0x01000001 over 0 → with DMEM_MISALIGN_ERR_EN: err 1, word stays 0; without it: err 0, word reads 0x0000BEEF.
